cdc_handshake_tx: RTL and testbench

Source-domain end of a 4-phase req/ack clock-domain-crossing handshake. It accepts a WIDTH-bit word from local logic through a valid/ready interface and holds it stable on a launch bus. It raises a request and waits for the asynchronous acknowledge from the destination domain, which it synchronizes internally. The destination-side responder samples the data through its multi-flop synchronizer, so the launch bus is held constant for the whole handshake.

---
 rtl/cdc_handshake_tx.sv | 138 +++++++++++++
 tb/tb_cdc_handshake_tx.sv | 294 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cdc_handshake_tx.sv
// cdc_handshake_tx
// Source-domain end of a 4-phase req/ack clock-domain crossing. A word taken
// on the valid/ready side is registered onto the launch bus. One cycle later
// the request rises, and the block then waits for the synchronized
// acknowledge to rise and fall again. The launch bus is held constant from
// the accept edge until the handshake completes, so the destination can
// sample it through its own synchronizer.
//
// Ports
//   clk          source-domain clock
//   reset        synchronous, active-high reset
//   in_valid     local word available
//   in_data      local word (WIDTH bits)
//   in_ready     a word can be accepted this cycle (decoded from registers)
//   xfer_data_o  registered launch bus to the destination domain
//   xfer_req_o   registered handshake request
//   xfer_ack_i   acknowledge from the destination, asynchronous to clk
//   done         one-cycle pulse when a handshake completes
//   busy         a handshake is in progress
//   xfer_count   count of completed handshakes, wraps
//
// state    | meaning
// ---------+-----------------------------------------------------------
// IDLE     | waiting for a word; blocked while the synchronized ack is high
// SETUP    | launch data driven, req still low (data leads req by one clk)
// REQ      | req high, waiting for the synchronized ack to rise
// RELEASE  | req low, waiting for the synchronized ack to fall

module cdc_handshake_tx #(
  parameter int WIDTH       = 8,
  parameter int SYNC_STAGES = 3,
  parameter int COUNT_WIDTH = 16
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   in_valid,
  input  logic [WIDTH-1:0]       in_data,
  output logic                   in_ready,
  output logic [WIDTH-1:0]       xfer_data_o,
  output logic                   xfer_req_o,
  input  logic                   xfer_ack_i,
  output logic                   done,
  output logic                   busy,
  output logic [COUNT_WIDTH-1:0] xfer_count
);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_SETUP   = 2'd1,
    S_REQ     = 2'd2,
    S_RELEASE = 2'd3
  } state_t;

  state_t                   state_q, state_d;
  logic [SYNC_STAGES-1:0]   ack_sync_q;
  logic                     ack_sync;
  logic [WIDTH-1:0]         data_q, data_d;
  logic                     req_q, req_d;
  logic                     done_q, done_d;
  logic [COUNT_WIDTH-1:0]   count_q, count_d;

  // Ack synchronizer: bit 0 samples the asynchronous input, the last bit is
  // the only one the FSM looks at.
  always_ff @(posedge clk) begin
    if (reset) begin
      ack_sync_q <= '0;
    end else begin
      ack_sync_q <= {ack_sync_q[SYNC_STAGES-2:0], xfer_ack_i};
    end
  end

  assign ack_sync = ack_sync_q[SYNC_STAGES-1];

  // A stale ack (e.g. left high across a reset) keeps new words out until
  // the destination has let go of it.
  assign in_ready = (state_q == S_IDLE) && !ack_sync;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      data_q  <= '0;
      req_q   <= 1'b0;
      done_q  <= 1'b0;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      req_q   <= req_d;
      done_q  <= done_d;
      count_q <= count_d;
    end
  end

  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    req_d   = req_q;
    done_d  = 1'b0;
    count_d = count_q;
    case (state_q)
      S_IDLE: begin
        if (in_valid && in_ready) begin
          data_d  = in_data;
          state_d = S_SETUP;
        end
      end
      S_SETUP: begin
        req_d   = 1'b1;
        state_d = S_REQ;
      end
      S_REQ: begin
        // A falling ack here cannot matter: only the rising level is looked for.
        if (ack_sync) begin
          req_d   = 1'b0;
          state_d = S_RELEASE;
        end
      end
      S_RELEASE: begin
        if (!ack_sync) begin
          state_d = S_IDLE;
          done_d  = 1'b1;
          count_d = count_q + COUNT_WIDTH'(1);
        end
      end
      default: begin
        state_d = S_IDLE;
        req_d   = 1'b0;
      end
    endcase
  end

  assign xfer_data_o = data_q;
  assign xfer_req_o  = req_q;
  assign done        = done_q;
  assign busy        = (state_q != S_IDLE);
  assign xfer_count  = count_q;

endmodule

// File: tb/tb_cdc_handshake_tx.sv
module tb_cdc_handshake_tx;

  localparam int SYNC = 3;

  logic        clk;
  logic        reset;
  logic        in_valid;
  logic [7:0]  in_data;
  logic        in_ready;
  logic [7:0]  xfer_data_o;
  logic        xfer_req_o;
  logic        xfer_ack_i;
  logic        done;
  logic        busy;
  logic [15:0] xfer_count;

  logic        in_ready_w2;
  logic [7:0]  xfer_data_w2;
  logic        xfer_req_w2;
  logic        done_w2;
  logic        busy_w2;
  logic [1:0]  xfer_count_w2;

  // destination-side responder
  logic        resp_en;
  logic        resp_ack;
  logic        man_ack;
  int          resp_dly;
  int          resp_cnt;
  logic [7:0]  rx_q[$];

  int checks;
  int failures;
  int n_xfer;
  logic [7:0] exp_data;

  logic [7:0] stim_words[$];
  int         stim_gaps[$];

  assign xfer_ack_i = resp_en ? resp_ack : man_ack;

  cdc_handshake_tx #(.WIDTH(8), .SYNC_STAGES(SYNC), .COUNT_WIDTH(16)) u_dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready), .xfer_data_o(xfer_data_o), .xfer_req_o(xfer_req_o),
    .xfer_ack_i(xfer_ack_i), .done(done), .busy(busy), .xfer_count(xfer_count)
  );

  cdc_handshake_tx #(.WIDTH(8), .SYNC_STAGES(SYNC), .COUNT_WIDTH(2)) u_dut_w2 (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready_w2), .xfer_data_o(xfer_data_w2), .xfer_req_o(xfer_req_w2),
    .xfer_ack_i(xfer_ack_i), .done(done_w2), .busy(busy_w2), .xfer_count(xfer_count_w2)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Follows req after resp_dly edges of disagreement; captures data on ack rise.
  always @(posedge clk) begin
    logic tgt;
    if (!resp_en) begin
      resp_cnt = 0;
    end else if (xfer_req_o !== resp_ack) begin
      resp_cnt = resp_cnt + 1;
      if (resp_cnt >= resp_dly) begin
        resp_cnt = 0;
        tgt = xfer_req_o;
        if (tgt) rx_q.push_back(xfer_data_o);
        #1 resp_ack = tgt;
      end
    end else begin
      resp_cnt = 0;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    resp_en = 1'b0; man_ack = 1'b0; resp_ack = 1'b0;
    in_valid = 1'b0; in_data = 8'h00;
    reset = 1'b1;
    repeat (3) tick();
    reset = 1'b0;
    n_xfer = 0; exp_data = 8'h00;
    checks++; if (xfer_req_o !== 1'b0) begin failures++; $display("FAIL reset_req got=%b exp=0", xfer_req_o); end
    checks++; if (xfer_data_o !== 8'h00) begin failures++; $display("FAIL reset_data got=%h exp=00", xfer_data_o); end
    checks++; if (done !== 1'b0) begin failures++; $display("FAIL reset_done got=%b exp=0", done); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", busy); end
    checks++; if (xfer_count !== 16'd0) begin failures++; $display("FAIL reset_count got=%0d exp=0", xfer_count); end
    checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL reset_in_ready got=%b exp=1", in_ready); end
  endtask

  // Drives stim_words with the responder enabled and checks every cycle against
  // a timeline computed from the handshake period T = 3 + 2*D + 2*SYNC.
  task automatic run_stream(input string name, input bit b2b, input bit junk_ff);
    int n, T, free_at, last, s;
    int acc[$];
    int st[$];
    bit v, b_e, r_e, d_e;
    logic [7:0] dat_e;
    n = stim_words.size();
    T = 3 + 2*resp_dly + 2*SYNC;
    free_at = 0;
    for (int i = 0; i < n; i++) begin
      if (i == 0) s = b2b ? 0 : stim_gaps[0];
      else        s = acc[i-1] + 1 + (b2b ? 0 : stim_gaps[i]);
      st.push_back(s);
      acc.push_back((s > free_at) ? s : free_at);
      free_at = acc[i] + T + 1;
    end
    last = acc[n-1] + T + 2;
    rx_q.delete();
    resp_cnt = 0;
    resp_en = 1'b1;
    for (int e = 0; e <= last; e++) begin
      v = 1'b0;
      in_data = junk_ff ? 8'hFF : 8'($urandom_range(0, 255));
      for (int i = 0; i < n; i++) begin
        if (st[i] <= e && e <= acc[i]) begin
          v = 1'b1;
          if (e == acc[i]) in_data = stim_words[i];
        end
      end
      in_valid = v;
      tick();
      b_e = 1'b0; r_e = 1'b0; d_e = 1'b0; dat_e = exp_data;
      for (int i = 0; i < n; i++) begin
        if (acc[i] <= e && e < acc[i] + T) b_e = 1'b1;
        if (acc[i] + 1 <= e && e < acc[i] + 2 + resp_dly + SYNC) r_e = 1'b1;
        if (e == acc[i] + T) d_e = 1'b1;
        if (acc[i] <= e) dat_e = stim_words[i];
      end
      if (d_e) n_xfer++;
      checks++; if (busy !== b_e) begin failures++; $display("FAIL %s_busy e=%0d got=%b exp=%b", name, e, busy, b_e); end
      checks++; if (in_ready !== !b_e) begin failures++; $display("FAIL %s_in_ready e=%0d got=%b exp=%b", name, e, in_ready, !b_e); end
      checks++; if (xfer_req_o !== r_e) begin failures++; $display("FAIL %s_req e=%0d got=%b exp=%b", name, e, xfer_req_o, r_e); end
      checks++; if (done !== d_e) begin failures++; $display("FAIL %s_done e=%0d got=%b exp=%b", name, e, done, d_e); end
      checks++; if (xfer_data_o !== dat_e) begin failures++; $display("FAIL %s_data e=%0d got=%h exp=%h", name, e, xfer_data_o, dat_e); end
      checks++; if (xfer_count !== 16'(n_xfer)) begin failures++; $display("FAIL %s_count e=%0d got=%0d exp=%0d", name, e, xfer_count, 16'(n_xfer)); end
      checks++; if (xfer_count_w2 !== 2'(n_xfer)) begin failures++; $display("FAIL %s_count_w2 e=%0d got=%0d exp=%0d", name, e, xfer_count_w2, 2'(n_xfer)); end
    end
    in_valid = 1'b0;
    exp_data = stim_words[n-1];
    checks++;
    if (rx_q.size() != n) begin
      failures++; $display("FAIL %s_rx_count got=%0d exp=%0d", name, rx_q.size(), n);
    end else begin
      for (int i = 0; i < n; i++) begin
        if (rx_q[i] !== stim_words[i]) begin
          failures++; $display("FAIL %s_rx_word i=%0d got=%h exp=%h", name, i, rx_q[i], stim_words[i]);
        end
      end
    end
    resp_en = 1'b0;
  endtask

  task automatic test_single();
    resp_dly = 2;
    stim_words = '{8'hA5};
    stim_gaps = '{0};
    run_stream("single", 1'b0, 1'b0);
  endtask

  task automatic test_back_to_back();
    resp_dly = 2;
    stim_words = '{8'h01, 8'h02, 8'h03};
    stim_gaps = '{0, 0, 0};
    run_stream("b2b", 1'b1, 1'b1);
  endtask

  task automatic test_random(input int n, input int dly);
    resp_dly = dly;
    stim_words.delete();
    stim_gaps.delete();
    for (int i = 0; i < n; i++) begin
      stim_words.push_back(8'($urandom_range(0, 255)));
      stim_gaps.push_back(int'($urandom_range(0, 3 + 2*dly + 2*SYNC + 3)));
    end
    run_stream("random", 1'b0, 1'b0);
  endtask

  task automatic test_count_wrap();
    resp_dly = 1;
    stim_words = '{8'h10, 8'h20, 8'h30, 8'h40, 8'h50};
    stim_gaps = '{1, 0, 2, 0, 1};
    run_stream("wrap", 1'b0, 1'b0);
  endtask

  task automatic test_glitch();
    bit seen;
    resp_en = 1'b0; man_ack = 1'b0;
    in_valid = 1'b1; in_data = 8'h5A;
    tick();
    in_valid = 1'b0;
    seen = 1'b0;
    for (int k = 0; k < 10 && !seen; k++) begin tick(); seen = (xfer_req_o === 1'b1); end
    checks++; if (!seen) begin failures++; $display("FAIL glitch_req_rise got=%b exp=1", xfer_req_o); end
    man_ack = 1'b1;
    seen = 1'b0;
    for (int k = 0; k < 20 && !seen; k++) begin tick(); seen = (xfer_req_o === 1'b0); end
    checks++; if (!seen) begin failures++; $display("FAIL glitch_req_fall got=%b exp=0", xfer_req_o); end
    tick(); tick();
    checks++; if (busy !== 1'b1 || done !== 1'b0) begin failures++; $display("FAIL glitch_release_hold busy=%b done=%b exp busy=1 done=0", busy, done); end
    man_ack = 1'b0;
    tick();
    man_ack = 1'b1;
    tick();
    man_ack = 1'b0;
    // low-high-low on ack: the first low completes, the late spike only delays in_ready
    for (int k = 1; k <= SYNC + 4; k++) begin
      checks++;
      if (k < SYNC) begin
        if (busy !== 1'b1 || done !== 1'b0) begin failures++; $display("FAIL glitch_wait k=%0d busy=%b done=%b exp busy=1 done=0", k, busy, done); end
      end else if (k == SYNC) begin
        if (busy !== 1'b0 || done !== 1'b1 || in_ready !== 1'b0) begin
          failures++; $display("FAIL glitch_done k=%0d busy=%b done=%b in_ready=%b exp 0 1 0", k, busy, done, in_ready);
        end
      end else begin
        if (busy !== 1'b0 || done !== 1'b0 || in_ready !== 1'b1) begin
          failures++; $display("FAIL glitch_after k=%0d busy=%b done=%b in_ready=%b exp 0 0 1", k, busy, done, in_ready);
        end
      end
      if (k == SYNC) n_xfer++;
      if (k < SYNC + 4) tick();
    end
    exp_data = 8'h5A;
    checks++; if (xfer_count !== 16'(n_xfer)) begin failures++; $display("FAIL glitch_count got=%0d exp=%0d", xfer_count, 16'(n_xfer)); end
    checks++; if (xfer_data_o !== 8'h5A) begin failures++; $display("FAIL glitch_data got=%h exp=5a", xfer_data_o); end
  endtask

  task automatic test_reset_mid();
    bit seen;
    resp_en = 1'b0; man_ack = 1'b0;
    in_valid = 1'b1; in_data = 8'h3C;
    tick();
    in_valid = 1'b0;
    seen = 1'b0;
    for (int k = 0; k < 10 && !seen; k++) begin tick(); seen = (xfer_req_o === 1'b1); end
    checks++; if (!seen) begin failures++; $display("FAIL rstmid_req_rise got=%b exp=1", xfer_req_o); end
    man_ack = 1'b1;
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    n_xfer = 0; exp_data = 8'h00;
    checks++; if (xfer_req_o !== 1'b0) begin failures++; $display("FAIL rstmid_req got=%b exp=0", xfer_req_o); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL rstmid_busy got=%b exp=0", busy); end
    checks++; if (done !== 1'b0) begin failures++; $display("FAIL rstmid_done got=%b exp=0", done); end
    checks++; if (xfer_count !== 16'd0 || xfer_count_w2 !== 2'd0) begin failures++; $display("FAIL rstmid_count got=%0d/%0d exp=0/0", xfer_count, xfer_count_w2); end
    repeat (SYNC) tick();
    // stale ack now visible; a word offered here must be refused
    in_valid = 1'b1; in_data = 8'hFF;
    for (int k = 0; k < 3; k++) begin
      checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL rstmid_blocked k=%0d got=%b exp=0", k, in_ready); end
      tick();
    end
    in_valid = 1'b0;
    checks++; if (busy !== 1'b0 || xfer_data_o !== 8'h00) begin failures++; $display("FAIL rstmid_no_accept busy=%b data=%h exp 0 00", busy, xfer_data_o); end
    man_ack = 1'b0;
    for (int k = 1; k <= SYNC + 1; k++) begin
      tick();
      checks++;
      if (in_ready !== (k >= SYNC)) begin failures++; $display("FAIL rstmid_ack_fall k=%0d got=%b exp=%b", k, in_ready, (k >= SYNC)); end
    end
    checks++; if (done !== 1'b0 || xfer_req_o !== 1'b0) begin failures++; $display("FAIL rstmid_quiet done=%b req=%b exp 0 0", done, xfer_req_o); end
  endtask

  initial begin
    checks = 0; failures = 0; n_xfer = 0; exp_data = 8'h00;
    resp_en = 1'b0; resp_ack = 1'b0; man_ack = 1'b0; resp_dly = 2; resp_cnt = 0;
    reset = 1'b1; in_valid = 1'b0; in_data = 8'h00;
    test_reset();
    test_single();
    test_back_to_back();
    test_random(8, 1);
    test_random(6, 3);
    test_glitch();
    test_reset_mid();
    test_count_wrap();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
